// File: rtl/ysyx_24090012_ifu_if.sv
// Fetch-side bundle: instruction memory port, decode handoff and EXU retire feedback.
// Performance counter signals exist only when IFU_PERF_CNT_EN is defined.
interface ysyx_24090012_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        ex_done;
  logic [31:0] next_pc;
  logic        fetch_fault;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_fault,
`ifdef IFU_PERF_CNT_EN
    output perf_fetch_cnt, perf_stall_cnt,
`endif
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  inst_ready, ex_done, next_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_fault,
`ifdef IFU_PERF_CNT_EN
    input  perf_fetch_cnt, perf_stall_cnt,
`endif
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output inst_ready, ex_done, next_pc
  );
endinterface

// File: rtl/ysyx_24090012_ifu.sv
// Non-pipelined instruction fetch unit: owns the PC, fetches one instruction, hands it to decode,
// then waits for retire. Optional performance counters are enabled with IFU_PERF_CNT_EN.
module ysyx_24090012_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input logic                  clk,
  input logic                  rst,
  ysyx_24090012_ifu_if.master  bus
);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    EXEC  = 3'd4,
    FAULT = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] pc_r;
  logic [31:0] inst_r;
  logic        fault_r;
  logic        pc_load_s;
  logic        inst_load_s;
  logic        fault_set_s;

  // State register plus PC, instruction and sticky fault capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= BOOT;
      pc_r    <= RESET_PC;
      inst_r  <= 32'h0000_0000;
      fault_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (pc_load_s) begin
        pc_r <= bus.next_pc;
      end
      if (inst_load_s) begin
        inst_r <= bus.imem_rsp_data;
      end
      if (fault_set_s) begin
        fault_r <= 1'b1;
      end
    end
  end

  // Next-state and load strobes; each input is only looked at in the state that owns it.
  always_comb begin
    state_nxt_s = state_r;
    pc_load_s   = 1'b0;
    inst_load_s = 1'b0;
    fault_set_s = 1'b0;
    case (state_r)
      BOOT: begin
        state_nxt_s = REQ;
      end
      REQ: begin
        if (bus.imem_req_ready) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (bus.imem_rsp_err) begin
            fault_set_s = 1'b1;
            state_nxt_s = FAULT;
          end else begin
            inst_load_s = 1'b1;
            state_nxt_s = HOLD;
          end
        end else begin
          state_nxt_s = WAIT;
        end
      end
      HOLD: begin
        if (bus.inst_ready) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      EXEC: begin
        if (bus.ex_done) begin
          pc_load_s   = 1'b1;
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = EXEC;
        end
      end
      FAULT: begin
        state_nxt_s = FAULT;
      end
      default: begin
        state_nxt_s = BOOT;
      end
    endcase
  end

  // Valids are pure state decodes, so reset drops them without waiting for a clock edge.
  assign bus.imem_req_valid = (state_r == REQ);
  assign bus.imem_req_addr  = pc_r;
  assign bus.inst_valid     = (state_r == HOLD);
  assign bus.inst           = inst_r;
  assign bus.inst_pc        = pc_r;
  assign bus.fetch_fault    = fault_r;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_r;
  logic [31:0] perf_stall_r;
  logic        fetch_hs_s;
  logic        stall_s;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    if (value == 32'hFFFF_FFFF) begin
      sat_inc = value;
    end else begin
      sat_inc = value + 32'd1;
    end
  endfunction

  // Event decode for the counters: decode handshake and memory-wait cycles.
  always_comb begin
    fetch_hs_s = 1'b0;
    stall_s    = 1'b0;
    if ((state_r == HOLD) && bus.inst_ready) begin
      fetch_hs_s = 1'b1;
    end else begin
      fetch_hs_s = 1'b0;
    end
    if (((state_r == REQ) && !bus.imem_req_ready) ||
        ((state_r == WAIT) && !bus.imem_rsp_valid)) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Saturating counters, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_r <= 32'd0;
      perf_stall_r <= 32'd0;
    end else begin
      if (fetch_hs_s) begin
        perf_fetch_r <= sat_inc(perf_fetch_r);
      end
      if (stall_s) begin
        perf_stall_r <= sat_inc(perf_stall_r);
      end
    end
  end

  assign bus.perf_fetch_cnt = perf_fetch_r;
  assign bus.perf_stall_cnt = perf_stall_r;
`endif

endmodule

// File: tb/tb_ysyx_24090012_ifu.sv
// Directed self-checking bench for ysyx_24090012_ifu; acts as both instruction memory and decode/EXU.
module tb_ysyx_24090012_ifu;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   accepts;

  ysyx_24090012_ifu_if bus ();

  ysyx_24090012_ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts request handshakes seen by memory.
  always @(posedge clk) begin
    if (!rst && bus.imem_req_valid && bus.imem_req_ready) begin
      accepts = accepts + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] wrap_pc;
  int          acc0;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] stall0;
  logic [31:0] fetch0;
`endif

  initial begin
    checks   = 0;
    failures = 0;
    accepts  = 0;
    rst = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.imem_rsp_err   = 1'b0;
    bus.inst_ready     = 1'b1;
    bus.ex_done        = 1'b0;
    bus.next_pc        = 32'h0;

    // Reset held three cycles.
    tick(); tick(); tick();
    check_eq("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    check_eq("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check_eq("rst_inst", bus.inst, 32'h0000_0000);
    check_eq("rst_inst_pc", bus.inst_pc, 32'h8000_0000);
    check_eq("rst_fault", {31'd0, bus.fetch_fault}, 32'd0);
`ifdef IFU_PERF_CNT_EN
    check_eq("rst_perf_fetch", bus.perf_fetch_cnt, 32'd0);
    check_eq("rst_perf_stall", bus.perf_stall_cnt, 32'd0);
`endif

    // Release: first cycle BOOT, second cycle REQ.
    rst = 1'b0;
    check_eq("boot_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    tick();
    check_eq("first_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    check_eq("first_req_addr", bus.imem_req_addr, 32'h8000_0000);

    // Basic fetch.
    tick();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0010_0093;
    tick();
    bus.imem_rsp_valid = 1'b0;
    check_eq("basic_inst_valid", {31'd0, bus.inst_valid}, 32'd1);
    check_eq("basic_inst", bus.inst, 32'h0010_0093);
    check_eq("basic_inst_pc", bus.inst_pc, 32'h8000_0000);
    tick();
    check_eq("basic_inst_valid_drop", {31'd0, bus.inst_valid}, 32'd0);

    // Response pulse outside WAIT is ignored.
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    bus.imem_rsp_valid = 1'b0;
    check_eq("stray_rsp_inst", bus.inst, 32'h0010_0093);

    // Redirect from EXEC.
    bus.ex_done = 1'b1;
    bus.next_pc = 32'h8000_0100;
    tick();
    bus.ex_done = 1'b0;
    check_eq("redir_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    check_eq("redir_addr", bus.imem_req_addr, 32'h8000_0100);

    // ex_done in REQ must not move pc.
    bus.imem_req_ready = 1'b0;
    bus.ex_done = 1'b1;
    bus.next_pc = 32'h1234_5678;
    tick();
    bus.ex_done = 1'b0;
    check_eq("req_exdone_addr", bus.imem_req_addr, 32'h8000_0100);
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0000_0013;
    bus.inst_ready     = 1'b0;
    tick();
    bus.imem_rsp_valid = 1'b0;
    // ex_done in HOLD must not move pc.
    bus.ex_done = 1'b1;
    tick();
    bus.ex_done = 1'b0;
    check_eq("hold_exdone_pc", bus.inst_pc, 32'h8000_0100);
    check_eq("hold_exdone_valid", {31'd0, bus.inst_valid}, 32'd1);
    bus.inst_ready = 1'b1;
    tick();

    // Jump to the top of the address space, then wrap with pc+4.
    bus.ex_done = 1'b1;
    bus.next_pc = 32'hFFFF_FFFC;
    tick();
    bus.ex_done = 1'b0;
    check_eq("top_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    tick();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0000_0073;
    tick();
    bus.imem_rsp_valid = 1'b0;
    check_eq("top_inst_pc", bus.inst_pc, 32'hFFFF_FFFC);
    tick();
    wrap_pc = 32'hFFFF_FFFC;
    wrap_pc = wrap_pc + 32'd4;
    bus.ex_done = 1'b1;
    bus.next_pc = wrap_pc;
    tick();
    bus.ex_done = 1'b0;
    check_eq("wrap_addr", bus.imem_req_addr, 32'h0000_0000);

    // Backpressure: memory not ready for 4 cycles, decode not ready for 3.
    acc0 = accepts;
`ifdef IFU_PERF_CNT_EN
    stall0 = bus.perf_stall_cnt;
    fetch0 = bus.perf_fetch_cnt;
`endif
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("bp_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
      check_eq("bp_req_addr", bus.imem_req_addr, 32'h0000_0000);
    end
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hAABB_CCDD;
    bus.inst_ready     = 1'b0;
    tick();
    bus.imem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_inst_valid", {31'd0, bus.inst_valid}, 32'd1);
      check_eq("bp_inst", bus.inst, 32'hAABB_CCDD);
      check_eq("bp_inst_pc", bus.inst_pc, 32'h0000_0000);
      tick();
    end
    bus.inst_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b1;
    check_eq("bp_accepts", accepts - acc0, 32'd1);
`ifdef IFU_PERF_CNT_EN
    check_eq("bp_perf_stall", bus.perf_stall_cnt - stall0, 32'd4);
    check_eq("bp_perf_fetch", bus.perf_fetch_cnt - fetch0, 32'd1);
`endif

    // Access fault is terminal until reset.
    bus.ex_done = 1'b1;
    bus.next_pc = 32'h8000_0200;
    tick();
    bus.ex_done = 1'b0;
    tick();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_err   = 1'b1;
    tick();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_err   = 1'b0;
    check_eq("fault_flag", {31'd0, bus.fetch_fault}, 32'd1);
    acc0 = accepts;
    for (int i = 0; i < 4; i++) begin
      bus.imem_rsp_valid = 1'b1;
      bus.ex_done        = 1'b1;
      tick();
      check_eq("fault_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
      check_eq("fault_no_inst", {31'd0, bus.inst_valid}, 32'd0);
    end
    bus.imem_rsp_valid = 1'b0;
    bus.ex_done        = 1'b0;
    check_eq("fault_sticky", {31'd0, bus.fetch_fault}, 32'd1);
    check_eq("fault_accepts", accepts - acc0, 32'd0);
    rst = 1'b1;
    #1;
    check_eq("fault_rst_clear", {31'd0, bus.fetch_fault}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check_eq("refetch_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    check_eq("refetch_addr", bus.imem_req_addr, 32'h8000_0000);

    // Get non-reset state into inst/pc, then reset asynchronously while in WAIT.
    tick();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0050_0113;
    tick();
    bus.imem_rsp_valid = 1'b0;
    tick();
    bus.ex_done = 1'b1;
    bus.next_pc = 32'h8000_0040;
    tick();
    bus.ex_done = 1'b0;
    check_eq("pre_async_addr", bus.imem_req_addr, 32'h8000_0040);
    tick();
    check_eq("pre_async_inst", bus.inst, 32'h0050_0113);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_inst", bus.inst, 32'h0000_0000);
    check_eq("async_pc", bus.inst_pc, 32'h8000_0000);
    check_eq("async_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    check_eq("async_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check_eq("post_async_req", {31'd0, bus.imem_req_valid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
